i2s: RTL and testbench
======================

// Module: i2s
// PURPOSE
//  I2S master receiver for a PCM1808-class stereo ADC. From the system clock it generates
//  SCKI (256fs), BCK (64fs) and LRCK (fs), deserialises 24-bit two's-complement samples
//  from din and presents the latest left/right words. Sits between the ADC pins and the
//  DSP/FFT datapath, all in the clk domain.
// PARAMETERS
//  DATA_W  24  sample width, MSB first; must be <= 31
//  CNT_W   8   frame counter width; LRCK period = 2**CNT_W clk cycles (256)
// PORTS
//  clk    in   1       system clock (nominal 12.288 MHz = 256fs); sole clock
//  reset  in   1       asynchronous, active-high reset
//  din    in   1       serial data from ADC
//  bck    out  1       bit clock = clk/4, registered
//  lrck   out  1       word clock = clk/256, registered; 0 = left, 1 = right
//  scki   out  1       ADC system clock = clk forwarded, not gated by reset
//  left   out  DATA_W  last complete left sample
//  right  out  DATA_W  last complete right sample
// BEHAVIOUR
//  - Free-running counter cnt[CNT_W-1:0] increments every clk and wraps 255->0.
//  - Outputs: bck = cnt[1], lrck = cnt[7]. Both are driven from registers (cnt bits).
//    One half-frame = 32 BCK periods. Bit slot b = cnt[6:2].
//  - Reset: cnt=0, bck=0, lrck=0, shift reg=0, left=0, right=0. scki keeps toggling.
//    Reset asserted mid-frame aborts the word; the first word after release starts at cnt=0.
//  - Shift event: the clk edge where pre-edge cnt[1:0]==2'b01 (bck rises on that edge).
//    On that edge din is sampled into sh <= {sh[DATA_W-2:0], din}.
//  - I2S format (default): MSB arrives in slot b=1 (1-BCK delay after LRCK edge), LSB in
//    b=DATA_W. Slots 0 and DATA_W+1..31 are ignored.
//  - Load: on the edge with pre-edge cnt[6:0] == 4*DATA_W+2 (98): if cnt[7]==0, left<=sh;
//    else right<=sh. The other channel holds. Latency = 1 clk after the LSB shift.
//  - left/right change only on a load edge; each updates once per frame (fs).
//  - din is not synchronised; it is launched by the ADC on the BCK falling edge and is
//    stable at the shift edge.
// CONFIGURATION
//  - I2S_LJ_FORMAT_EN defined: left-justified format. MSB is in slot b=0 and the LSB in
//    b=DATA_W-1. Load occurs at pre-edge cnt[6:0] == 4*DATA_W-2 (94).
//  - Not defined: standard I2S format as above.
// STRUCTURE
//  - Package i2s_pkg holds:
//    - localparam DATA_W, CNT_W, BCK_DIV=4;
//    - typedef logic [DATA_W-1:0] sample_t;
//    - the load-slot constants for both formats.
//  - Optional sub-module i2s_clkgen: counter plus bck/lrck/scki generation and a shift
//    strobe. The top level holds the shift register and the output registers.
// TESTING
//  1. Hold reset for 10 clk: bck=0, lrck=0, left=right=0, scki toggling. After release,
//     bck has a 4-clk period and lrck a 256-clk period (high from cnt=128).
//  2. Drive left word 24'hA5F00F in I2S timing (MSB at slot 1), right word 24'h000000:
//     after the frame, left=24'hA5F00F and right=0. left updates at pre-edge cnt=98.
//  3. Drive right word 24'h800001 while left is held: right=24'h800001 after the load at
//     cnt=226, and left is unchanged.
//  4. Hold din=1 for two frames: left=right=24'hFFFFFF. Then hold din=0: both return to 0
//     on their respective next load edges.
//  5. Assert reset at cnt=60 in the left half: left/right clear immediately (async).
//     Restart at cnt=0, and the next full word is captured correctly.
//  6. With I2S_LJ_FORMAT_EN: MSB at slot 0, word 24'h123456 -> left=24'h123456.
//     Load occurs at pre-edge cnt=94.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S master receiver.
// Load-slot constants for both standard I2S and left-justified (I2S_LJ_FORMAT_EN) framing.
package i2s_pkg;

  localparam int DATA_W  = 24;
  localparam int CNT_W   = 8;
  localparam int BCK_DIV = 4;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  // Load one clk after the LSB shift edge (pre-edge cnt[1:0]==01 of the LSB slot).
  localparam logic [CNT_W-2:0] LOAD_SLOT_I2S = (CNT_W-1)'(BCK_DIV*DATA_W + 2);
  localparam logic [CNT_W-2:0] LOAD_SLOT_LJ  = (CNT_W-1)'(BCK_DIV*DATA_W - 2);

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running frame counter producing BCK, LRCK, forwarded SCKI and the shift strobe.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_bck,
  output logic             o_lrck,
  output logic             o_scki,
  output logic             o_shift
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt   = r_cnt;
  assign o_bck   = r_cnt[1];
  assign o_lrck  = r_cnt[CNT_W-1];
  assign o_scki  = i_clk;
  // BCK rises on this edge; din is stable since the ADC launched it on the falling edge.
  assign o_shift = (r_cnt[1:0] == 2'b01);

endmodule

// File: rtl/i2s.sv
// I2S master receiver: generates SCKI/BCK/LRCK and deserialises stereo samples from din.
// Define I2S_LJ_FORMAT_EN for left-justified framing; default is standard I2S.
module i2s
  import i2s_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    din,
  output logic    bck,
  output logic    lrck,
  output logic    scki,
  output sample_t left,
  output sample_t right
);

`ifdef I2S_LJ_FORMAT_EN
  localparam logic [CNT_W-2:0] LOAD_AT = LOAD_SLOT_LJ;
`else
  localparam logic [CNT_W-2:0] LOAD_AT = LOAD_SLOT_I2S;
`endif

  logic [CNT_W-1:0] w_cnt;
  logic             w_shift;
  logic             w_load;
  chan_t            w_chan;
  sample_t          r_sh;
  sample_t          r_left;
  sample_t          r_right;

  i2s_clkgen u_clkgen (
    .i_clk   (clk),
    .i_rst   (reset),
    .o_cnt   (w_cnt),
    .o_bck   (bck),
    .o_lrck  (lrck),
    .o_scki  (scki),
    .o_shift (w_shift)
  );

  assign w_chan = chan_t'(w_cnt[CNT_W-1]);
  assign w_load = (w_cnt[CNT_W-2:0] == LOAD_AT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_sh <= '0;
    else if (w_shift) r_sh <= {r_sh[DATA_W-2:0], din};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (w_load) begin
      if (w_chan == CH_LEFT) r_left  <= r_sh;
      else                   r_right <= r_sh;
    end
  end

  assign left  = r_left;
  assign right = r_right;

endmodule

// File: tb/tb_i2s.sv
// Scoreboard bench for i2s: drives ADC-timed serial words, checks clocks and loaded samples.
module tb_i2s;

  localparam int DW = 24;
`ifdef I2S_LJ_FORMAT_EN
  localparam int FIRST_SLOT = 0;
  localparam int LOAD_AT    = 94;
`else
  localparam int FIRST_SLOT = 1;
  localparam int LOAD_AT    = 98;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          din;
  logic          bck, lrck, scki;
  logic [DW-1:0] left, right;

  i2s dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .bck   (bck),
    .lrck  (lrck),
    .scki  (scki),
    .left  (left),
    .right (right)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ch;
    logic [DW-1:0] w;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] exp_l;
  logic [DW-1:0] exp_r;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // fill: 0/1 constant level in unused slots, 2 random
  function automatic logic slot_bit(input logic [DW-1:0] w, input int b, input int fill);
    if (b >= FIRST_SLOT && b < FIRST_SLOT + DW) return w[DW-1-(b-FIRST_SLOT)];
    if (fill == 2) return 1'($urandom_range(1, 0));
    return (fill != 0);
  endfunction

  // c = pre-edge counter value of the posedge that follows each negedge
  task automatic run_frame(input logic [DW-1:0] wl, input logic [DW-1:0] wr,
                           input int fill, input int ncyc);
    logic [7:0] cc;
    logic [7:0] post;
    exp_t       e;
    for (int c = 0; c < ncyc; c++) begin
      cc = 8'(c);
      @(negedge clk);
      if (cc == 8'd0)   sb_q.push_back('{1'b0, wl});
      if (cc == 8'd128) sb_q.push_back('{1'b1, wr});
      din = slot_bit(cc[7] ? wr : wl, int'(cc[6:2]), fill);
      @(posedge clk);
      #1;
      post = cc + 8'd1;
      if (int'(cc[6:0]) == LOAD_AT) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_val("load_chan", 32'(cc[7]), 32'(e.ch));
          if (e.ch) exp_r = e.w;
          else      exp_l = e.w;
        end
      end
      check_val("bck",   32'(bck),   32'(post[1]));
      check_val("lrck",  32'(lrck),  32'(post[7]));
      check_val("scki",  32'(scki),  32'd1);
      check_val("left",  32'(left),  32'(exp_l));
      check_val("right", 32'(right), 32'(exp_r));
    end
  endtask

  task automatic hold_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_bck",   32'(bck),   32'd0);
      check_val("rst_lrck",  32'(lrck),  32'd0);
      check_val("rst_left",  32'(left),  32'd0);
      check_val("rst_right", 32'(right), 32'd0);
      check_val("rst_scki_hi", 32'(scki), 32'd1);
      @(negedge clk);
      #1;
      check_val("rst_scki_lo", 32'(scki), 32'd0);
    end
    // release mid high-phase so the next posedge sees cnt=0
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    exp_l = '0;
    exp_r = '0;
    hold_reset(10);

    run_frame(24'hA5F00F, 24'h000000, 2, 256);
    run_frame(24'hA5F00F, 24'h800001, 2, 256);
    run_frame(24'hFFFFFF, 24'hFFFFFF, 1, 256);
    run_frame(24'hFFFFFF, 24'hFFFFFF, 1, 256);
    run_frame(24'h000000, 24'h000000, 0, 256);
    run_frame(24'h123456, 24'h654321, 2, 256);

    // abort a word mid left half; outputs must clear asynchronously
    run_frame(24'h5A5A5A, 24'h3C3C3C, 2, 60);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("async_left",  32'(left),  32'd0);
    check_val("async_right", 32'(right), 32'd0);
    check_val("async_bck",   32'(bck),   32'd0);
    check_val("async_lrck",  32'(lrck),  32'd0);
    sb_q.delete();
    exp_l = '0;
    exp_r = '0;
    hold_reset(3);

    run_frame(24'hC3C3C3, 24'h3C3C3C, 2, 256);
    run_frame(24'h7FFFFF, 24'h800000, 2, 256);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
